// File: rtl/bus_control_unit.sv
// V30MZ bus control unit: instruction prefetch queue, prefetch pointer and the 16-bit bus arbiter.
// Optional BCU_PERF_COUNTERS_EN adds saturating fetch / EU / wait-state cycle counters.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | bus free; EU request wins over prefetch
// FETCH    | code prefetch at {ps,0}+pfp, held until readyb=0
// EU_READ  | EU data read at eu_addr, held until readyb=0
// EU_WRITE | EU data write at eu_addr, held until readyb=0
module bus_control_unit #(
  parameter int QUEUE_DEPTH        = 8,
  parameter int PREFETCH_THRESHOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ps,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  input  logic        q_pop,
  output logic [7:0]  q_data,
  output logic        q_valid,
  output logic [15:0] pfp,
  input  logic        eu_req,
  input  logic        eu_we,
  input  logic [19:0] eu_addr,
  input  logic [15:0] eu_wdata,
  output logic        eu_ack,
  output logic [15:0] eu_rdata,
  input  logic        readyb,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic [19:0] address_out,
  output logic [3:0]  bus_status
`ifdef BCU_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetch_cycles,
  output logic [31:0] perf_eu_cycles,
  output logic [31:0] perf_wait_cycles
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] THR_C   = CW'(PREFETCH_THRESHOLD);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    EU_READ  = 2'd2,
    EU_WRITE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     pfp_q, pfp_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [QUEUE_DEPTH];
  logic [7:0]      mem_d [QUEUE_DEPTH];
  logic            discard_q, discard_d;
  logic            eu_ack_q, eu_ack_d;
  logic [15:0]     eu_rdata_q, eu_rdata_d;

  logic [CW-1:0]   free_bytes;
  logic            prefetch_ok;
  logic            bus_done;
  logic            fetch_done;
  logic            push_en;
  logic            push_two;
  logic            pop_en;
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   pop_n;
  logic [PW-1:0]   wr_ptr_nx;
  logic [19:0]     fetch_addr;

  assign free_bytes  = DEPTH_C - count_q;
  // An odd pfp fetches a single byte, so one free slot is enough.
  assign prefetch_ok = pfp_q[0] ? (free_bytes != '0) : (free_bytes >= THR_C);
  assign bus_done    = (state_q != IDLE) && !readyb;
  assign fetch_done  = (state_q == FETCH) && !readyb;
  assign push_en     = fetch_done && !discard_q && !flush;
  assign push_two    = !pfp_q[0];
  assign pop_en      = q_pop && (count_q != '0) && !flush;
  assign push_n      = push_en ? (push_two ? CW'(2) : CW'(1)) : '0;
  assign pop_n       = pop_en ? CW'(1) : '0;
  assign wr_ptr_nx   = wr_ptr_q + PW'(1);
  assign fetch_addr  = {ps, 4'h0} + {4'h0, pfp_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (eu_req) begin
          state_d = eu_we ? EU_WRITE : EU_READ;
        end else if (prefetch_ok) begin
          state_d = FETCH;
        end
      end
      FETCH, EU_READ, EU_WRITE: begin
        if (!readyb) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pfp_d    = pfp_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pfp_d    = flush_pc;
    end else begin
      if (push_en) begin
        if (push_two) begin
          mem_d[wr_ptr_q]  = data_in[7:0];
          mem_d[wr_ptr_nx] = data_in[15:8];
          wr_ptr_d         = wr_ptr_q + PW'(2);
          pfp_d            = pfp_q + 16'd2;
        end else begin
          mem_d[wr_ptr_q]  = data_in[15:8];
          wr_ptr_d         = wr_ptr_nx;
          pfp_d            = pfp_q + 16'd1;
        end
      end
      if (pop_en) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + push_n - pop_n;
    end
  end

  // A flush during a fetch lets the bus cycle finish but drops its data.
  always_comb begin
    discard_d = 1'b0;
    if ((state_q == FETCH) && readyb) discard_d = discard_q | flush;
  end

  always_comb begin
    eu_ack_d   = bus_done && ((state_q == EU_READ) || (state_q == EU_WRITE));
    eu_rdata_d = eu_rdata_q;
    if ((state_q == EU_READ) && !readyb) eu_rdata_d = data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pfp_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      discard_q  <= 1'b0;
      eu_ack_q   <= 1'b0;
      eu_rdata_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pfp_q      <= pfp_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      eu_ack_q   <= eu_ack_d;
      eu_rdata_q <= eu_rdata_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    bus_status  = 4'hF;
    address_out = fetch_addr;
    data_out    = '0;
    unique case (state_q)
      IDLE:     bus_status = 4'hF;
      FETCH:    bus_status = 4'b1000;
      EU_READ: begin
        bus_status  = 4'b1001;
        address_out = eu_addr;
      end
      EU_WRITE: begin
        bus_status  = 4'b1010;
        address_out = eu_addr;
        data_out    = eu_wdata;
      end
      default:  bus_status = 4'hF;
    endcase
  end

  assign q_valid  = (count_q != '0);
  assign q_data   = q_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign pfp      = pfp_q;
  assign eu_ack   = eu_ack_q;
  assign eu_rdata = eu_rdata_q;

`ifdef BCU_PERF_COUNTERS_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_eu_q, perf_eu_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    perf_fetch_d = sat_inc(perf_fetch_q, state_q == FETCH);
    perf_eu_d    = sat_inc(perf_eu_q, (state_q == EU_READ) || (state_q == EU_WRITE));
    perf_wait_d  = sat_inc(perf_wait_q, (state_q != IDLE) && readyb);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_eu_q    <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_eu_q    <= perf_eu_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_fetch_cycles = perf_fetch_q;
  assign perf_eu_cycles    = perf_eu_q;
  assign perf_wait_cycles  = perf_wait_q;
`endif

endmodule

// File: tb/tb_bus_control_unit.sv
// Self-checking bench for bus_control_unit: byte-queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bus_control_unit;
  localparam int DEPTH = 8;
  localparam int THR   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ps = 16'hFFFF;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = 16'h0000;
  logic        q_pop = 1'b0;
  logic [7:0]  q_data;
  logic        q_valid;
  logic [15:0] pfp;
  logic        eu_req = 1'b0;
  logic        eu_we = 1'b0;
  logic [19:0] eu_addr = 20'h0;
  logic [15:0] eu_wdata = 16'h0;
  logic        eu_ack;
  logic [15:0] eu_rdata;
  logic        readyb = 1'b0;
  logic [15:0] data_in = 16'hBBAA;
  logic [15:0] data_out;
  logic [19:0] address_out;
  logic [3:0]  bus_status;

  always #5 clk = ~clk;

  bus_control_unit #(.QUEUE_DEPTH(DEPTH), .PREFETCH_THRESHOLD(THR)) dut (
    .clk(clk), .reset(reset), .ps(ps), .flush(flush), .flush_pc(flush_pc),
    .q_pop(q_pop), .q_data(q_data), .q_valid(q_valid), .pfp(pfp),
    .eu_req(eu_req), .eu_we(eu_we), .eu_addr(eu_addr), .eu_wdata(eu_wdata),
    .eu_ack(eu_ack), .eu_rdata(eu_rdata), .readyb(readyb), .data_in(data_in),
    .data_out(data_out), .address_out(address_out), .bus_status(bus_status)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: activity 0=idle 1=fetch 2=read 3=write, byte queue, pfp, ack/rdata.
  int         m_act = 0;
  logic [15:0] m_pfp = 16'h0;
  logic [7:0] mq[$];
  logic       m_ack = 1'b0;
  logic [15:0] m_rdata = 16'h0;
  bit         m_disc = 1'b0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin : model
    int  act_old;
    int  free_b;
    bit  done;
    bit  allowed;
    if (reset) begin
      m_act = 0; m_pfp = 16'h0; mq.delete(); m_ack = 1'b0; m_rdata = 16'h0; m_disc = 1'b0;
    end else begin
      act_old = m_act;
      free_b  = DEPTH - mq.size();
      allowed = m_pfp[0] ? (free_b >= 1) : (free_b >= THR);
      done    = (m_act != 0) && !readyb;
      m_ack   = done && (m_act >= 2);
      if (done && m_act == 2) m_rdata = data_in;
      if (flush) begin
        mq.delete();
        m_pfp = flush_pc;
      end else begin
        if (q_pop && mq.size() > 0) void'(mq.pop_front());
        if (act_old == 1 && done && !m_disc) begin
          if (m_pfp[0]) begin
            mq.push_back(data_in[15:8]);
            m_pfp = 16'(m_pfp + 16'd1);
          end else begin
            mq.push_back(data_in[7:0]);
            mq.push_back(data_in[15:8]);
            m_pfp = 16'(m_pfp + 16'd2);
          end
        end
      end
      m_disc = (act_old == 1 && !done) ? (m_disc | flush) : 1'b0;
      if (act_old == 0) m_act = eu_req ? (eu_we ? 3 : 2) : (allowed ? 1 : 0);
      else if (done) m_act = 0;
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin : compare
    logic [3:0]  es;
    logic [19:0] ea;
    logic [15:0] ed;
    if (chk_en) begin
      case (m_act)
        0: es = 4'hF;
        1: es = 4'h8;
        2: es = 4'h9;
        default: es = 4'hA;
      endcase
      ea = (m_act >= 2) ? eu_addr : 20'((int'(ps) * 16 + int'(m_pfp)) % 1048576);
      ed = (m_act == 3) ? eu_wdata : 16'h0;
      chk("m_bus_status", bus_status, es);
      chk("m_address_out", address_out, ea);
      chk("m_data_out", data_out, ed);
      chk("m_q_valid", q_valid, mq.size() > 0);
      chk("m_q_data", q_data, (mq.size() > 0) ? mq[0] : 8'h00);
      chk("m_pfp", pfp, m_pfp);
      chk("m_eu_ack", eu_ack, m_ack);
      chk("m_eu_rdata", eu_rdata, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_status(input logic [3:0] v, input int maxc);
    int n = 0;
    while (bus_status !== v && n < maxc) begin
      tick();
      n++;
    end
    chk("wait_status", bus_status, v);
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_status", bus_status, 4'hF);
    chk("reset_addr", address_out, 20'hFFFF0);
    chk("reset_qvalid", q_valid, 1'b0);
    reset = 1'b0;

    // First word fetch wraps to top of memory and pushes low byte first
    wait_status(4'h8, 4);
    chk("fetch0_addr", address_out, 20'hFFFF0);
    tick();
    chk("fetch0_qdata", q_data, 8'hAA);
    chk("fetch0_pfp", pfp, 16'h0002);
    chk("fetch0_idle", bus_status, 4'hF);

    // Fill the queue, then release one byte (no fetch) and a second byte (fetch)
    repeat (10) tick();
    chk("full_pfp", pfp, 16'h0008);
    chk("full_status", bus_status, 4'hF);
    q_pop = 1'b1; tick(); q_pop = 1'b0;
    chk("pop1_qdata", q_data, 8'hBB);
    repeat (3) tick();
    chk("pop1_nofetch", bus_status, 4'hF);
    chk("pop1_pfp", pfp, 16'h0008);
    q_pop = 1'b1; tick(); q_pop = 1'b0;
    chk("pop2_qdata", q_data, 8'hAA);
    wait_status(4'h8, 4);
    chk("pop2_addr", address_out, 20'hFFFF8);
    tick();
    chk("pop2_pfp", pfp, 16'h000A);
    repeat (4) tick();

    // Flush to an odd pfp: single-byte fetch, then word-aligned
    data_in = 16'h3412;
    flush = 1'b1; flush_pc = 16'h0005; tick(); flush = 1'b0;
    chk("flush_qvalid", q_valid, 1'b0);
    chk("flush_pfp", pfp, 16'h0005);
    wait_status(4'h8, 4);
    chk("odd_addr", address_out, 20'hFFFF5);
    tick();
    chk("odd_qdata", q_data, 8'h34);
    chk("odd_pfp", pfp, 16'h0006);
    wait_status(4'h8, 4);
    chk("even_addr", address_out, 20'hFFFF6);
    tick();
    chk("even_pfp", pfp, 16'h0008);

    // Flush during a wait-stated fetch: cycle completes, data discarded
    readyb = 1'b1;
    wait_status(4'h8, 4);
    repeat (3) tick();
    chk("wait_hold", bus_status, 4'h8);
    flush = 1'b1; flush_pc = 16'h0100; tick(); flush = 1'b0;
    chk("fl_fetch_qvalid", q_valid, 1'b0);
    chk("fl_fetch_pfp", pfp, 16'h0100);
    chk("fl_fetch_addr", address_out, 20'h000F0);
    data_in = 16'hDEAD; readyb = 1'b0; tick();
    chk("discard_qvalid", q_valid, 1'b0);
    chk("discard_pfp", pfp, 16'h0100);
    chk("discard_status", bus_status, 4'hF);

    // EU read arriving during a fetch waits for it, then one idle clock
    wait_status(4'h8, 4);
    eu_req = 1'b1; eu_we = 1'b0; eu_addr = 20'h12345; data_in = 16'h5A5A;
    tick();
    chk("eu_gap_idle", bus_status, 4'hF);
    tick();
    chk("eu_rd_status", bus_status, 4'h9);
    chk("eu_rd_addr", address_out, 20'h12345);
    tick();
    eu_req = 1'b0;
    chk("eu_ack_pulse", eu_ack, 1'b1);
    chk("eu_rdata", eu_rdata, 16'h5A5A);
    tick();
    chk("eu_ack_drop", eu_ack, 1'b0);
    chk("eu_rdata_hold", eu_rdata, 16'h5A5A);

    // EU write held in wait states, then reset mid-cycle
    data_in = 16'h7788;
    eu_req = 1'b1; eu_we = 1'b1; eu_addr = 20'hABCDE; eu_wdata = 16'hCAFE;
    wait_status(4'hA, 8);
    readyb = 1'b1;
    chk("eu_wr_data", data_out, 16'hCAFE);
    chk("eu_wr_addr", address_out, 20'hABCDE);
    repeat (2) tick();
    reset = 1'b1; eu_req = 1'b0; eu_we = 1'b0;
    tick();
    chk("rst_status", bus_status, 4'hF);
    chk("rst_ack", eu_ack, 1'b0);
    chk("rst_qvalid", q_valid, 1'b0);
    chk("rst_pfp", pfp, 16'h0000);
    chk("rst_dout", data_out, 16'h0000);
    reset = 1'b0; readyb = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_control_unit.md
Name: bus_control_unit

Overview:
Parametrised bus control unit (BCU) for the V30MZ core. It owns the instruction prefetch queue and the prefetch pointer (PFP), and arbitrates the single 16-bit external bus between code prefetch and execution-unit (EU) data reads and writes. It adds the following over the previous BCU:
- configurable queue depth and prefetch threshold;
- odd-address single-byte fetch;
- queue flush on branch, including discard of an in-flight prefetch;
- an explicit request/acknowledge handshake to the EU.

Parameters:
QUEUE_DEPTH, 8, prefetch queue capacity in bytes; power of two, at least 4.
PREFETCH_THRESHOLD, 2, minimum free bytes required before a word prefetch starts; range 2..QUEUE_DEPTH.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ps  in  16  program segment register
flush  in  1  one-cycle pulse: clear queue and load PFP
flush_pc  in  16  new PFP value, sampled when flush=1
q_pop  in  1  EU consumes the head byte; legal only when q_valid=1
q_data  out  8  head byte of the queue
q_valid  out  1  queue not empty
pfp  out  16  current prefetch pointer
eu_req  in  1  EU bus request; held high until eu_ack
eu_we  in  1  1 = write, 0 = read; stable while eu_req=1
eu_addr  in  20  EU physical address; stable while eu_req=1
eu_wdata  in  16  EU write data
eu_ack  out  1  one-cycle pulse: EU access complete
eu_rdata  out  16  read data; valid in the eu_ack cycle and held until the next ack
readyb  in  1  bus ready, active low
data_in  in  16  bus read data
data_out  out  16  bus write data
address_out  out  20  bus physical address
bus_status  out  4  bus cycle type

Behaviour:
- Reset values (synchronous reset; also applies mid-cycle, any in-flight bus cycle is abandoned):
  - state=IDLE, pfp=16'h0000, queue empty, q_valid=0, q_data=0;
  - eu_ack=0, eu_rdata=0, data_out=0, bus_status=4'hF;
  - address_out={ps,4'h0}+{4'h0,pfp}.
- FSM states: IDLE, FETCH, EU_READ, EU_WRITE.
- IDLE, evaluated at each clock edge; eu_req has priority:
  1. eu_req=1, eu_we=0 -> EU_READ.
  2. eu_req=1, eu_we=1 -> EU_WRITE.
  3. Else if a prefetch is allowed -> FETCH.
  4. Otherwise stay in IDLE.
  - Prefetch allowed: pfp even and free bytes >= PREFETCH_THRESHOLD, or pfp odd and free bytes >= 1.
- Each bus state holds until readyb=0 is sampled at a clock edge, then returns to IDLE. This gives one idle clock between bus cycles and a minimum of 2 clocks per access.
- Outputs by state:
  - bus_status: IDLE 4'hF, FETCH 4'b1000, EU_READ 4'b1001, EU_WRITE 4'b1010.
  - address_out: FETCH and IDLE drive {ps,4'h0}+{4'h0,pfp} modulo 2^20. EU states drive eu_addr.
  - data_out: eu_wdata in EU_WRITE, else 0.
- FETCH completion:
  - pfp even: push data_in[7:0] then data_in[15:8]; pfp += 2.
  - pfp odd: push only data_in[15:8]; pfp += 1. Subsequent fetches are word-aligned.
  - pfp wraps modulo 2^16 (segment wrap). The physical address wraps modulo 2^20.
- EU completion: eu_ack=1 in the next cycle. On a read, eu_rdata is captured from data_in at the completion edge. The EU must drop eu_req in the ack cycle, otherwise a new access is started.
- A push and a pop in the same cycle are both performed; the count changes by the number of pushed bytes minus 1.
- q_pop while empty is ignored and the count is unchanged (verification flags it as an assertion).
- Flush, effective at the next edge:
  - queue count=0, q_valid=0, pfp=flush_pc;
  - flush has priority over push and pop in the same cycle.
  - If FETCH is active, the cycle runs to completion on the bus, but its data is not pushed and pfp is not advanced.
  - EU cycles are unaffected by flush.
- Queue storage: circular buffer with read and write pointers of clog2(QUEUE_DEPTH) bits plus a count of clog2(QUEUE_DEPTH)+1 bits. The count never exceeds QUEUE_DEPTH; this is guaranteed by the prefetch-allowed rule.

Optional Feature:
BCU_PERF_COUNTERS_EN
- Defined: adds three outputs, each 32-bit, cleared on reset, saturating at 32'hFFFFFFFF:
  - perf_fetch_cycles: clocks spent in FETCH;
  - perf_eu_cycles: clocks spent in EU_READ or EU_WRITE;
  - perf_wait_cycles: clocks in any bus state with readyb=1.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset with ps=16'hFFFF, then readyb=0 constant -> first FETCH at address_out=20'hFFFF0 with bus_status=4'b1000. data_in=16'hBBAA pushes AA then BB, and pfp=2.
- flush with flush_pc=16'h0005, readyb=0 -> next FETCH at {ps,0}+5 pushes only data_in[15:8]. pfp=6, and the following fetch is a word fetch at 6.
- DEPTH=8 with no pops -> queue fills to 8. bus_status stays 4'hF, and a pop of 1 byte does not start a fetch until a second pop frees 2 bytes.
- FETCH in progress with readyb=1 for 3 clocks, then flush -> readyb=0 completes the cycle with no bytes pushed. q_valid=0 and pfp=flush_pc.
- eu_req read at 20'h12345 during FETCH -> fetch completes first, then one IDLE clock, then bus_status=4'b1001 with address_out=20'h12345. data_in=16'h5A5A gives eu_ack for one clock and eu_rdata=16'h5A5A.
- Reset asserted during EU_WRITE with readyb=1 -> next cycle bus_status=4'hF, eu_ack=0, q_valid=0, pfp=0.
